// File: rtl/fpu_arbiter.sv
// fpu_arbiter
//   Shares one FPU between two requesters. One operation is in flight at a
//   time. Each operation walks IDLE -> ISSUE -> CAPT -> RESP -> IDLE.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high in the preceding cycle. Ready never depends on the same-side
//   valid being held from a prior cycle, and a valid request may be held
//   across cycles without being dropped.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   req_valid[1:0], req_ready[1:0] : per-requester request handshake
//   req_a/req_b  : packed 32-bit operands, requester i owns bits [32i+31:32i]
//   req_op       : packed 3-bit opcodes, requester i owns bits [3i+2:3i]
//   fpu_a/fpu_b/fpu_opcode : registered operands to the shared FPU
//   fpu_result   : FPU result, valid one clock after operands are presented
//   resp_valid, resp_ready : response handshake
//   resp_data, resp_id     : captured result and owning requester
//   busy         : high whenever not IDLE
//   op_count     : completed responses, wraps modulo 2^CNT_W
module fpu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    input  logic [5:0]       req_op,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [2:0]       fpu_opcode,
    input  logic [31:0]      fpu_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic             resp_id,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic last_grant;
    logic owner;
    logic grant;
    logic accept;
    logic resp_fire;

    // Next state, grant and handshake decode
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        accept    = 1'b0;
        resp_fire = 1'b0;
        req_ready = 2'b00;

        // Round-robin: on contention the requester that did not win last time
        // gets the grant; a lone requester always wins.
        if (req_valid == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req_valid[1];
        end

        // Ready is withheld during reset so no request is consumed by the
        // reset edge.
        if (state == IDLE && (|req_valid) && !rst) begin
            accept    = 1'b1;
            req_ready = grant ? 2'b10 : 2'b01;
        end

        resp_fire = (state == RESP) && resp_ready;

        case (state)
            IDLE:    if (accept)    state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPT;
            CAPT:    state_nxt = RESP;
            RESP:    if (resp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            fpu_a      <= 32'd0;
            fpu_b      <= 32'd0;
            fpu_opcode <= 3'd0;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            resp_id    <= 1'b0;
            op_count   <= '0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                fpu_a      <= grant ? req_a[63:32] : req_a[31:0];
                fpu_b      <= grant ? req_b[63:32] : req_b[31:0];
                fpu_opcode <= grant ? req_op[5:3]  : req_op[2:0];
                owner      <= grant;
                last_grant <= grant;
            end

            // The FPU registered its result at the end of ISSUE, so it is
            // present on fpu_result throughout CAPT.
            if (state == CAPT) begin
                resp_data  <= fpu_result;
                resp_id    <= owner;
                resp_valid <= 1'b1;
            end

            if (resp_fire) begin
                resp_valid <= 1'b0;
                op_count   <= op_count + CNT_W'(1);
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter: CNT_W, 16, width of the completed-operation counter.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 Port: req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-006 Port: req_a  input  64  operand a; bits [32i+31:32i] belong to requester i.
REQ-007 Port: req_b  input  64  operand b, same packing as req_a.
REQ-008 Port: req_op  input  6  opcode; bits [3i+2:3i] belong to requester i.
REQ-009 Port: fpu_a  output  32  operand a to the shared FPU.
REQ-010 Port: fpu_b  output  32  operand b to the shared FPU.
REQ-011 Port: fpu_opcode  output  3  opcode to the shared FPU (000 add, 001 sub, 010 mul, 011 div, 100 pass a, others give 0).
REQ-012 Port: fpu_result  input  32  FPU result, registered by the FPU one clock after operands are presented.
REQ-013 Port: resp_valid  output  1  response valid.
REQ-014 Port: resp_ready  input  1  response consumer ready.
REQ-015 Port: resp_data  output  32  captured FPU result.
REQ-016 Port: resp_id  output  1  index of the requester owning resp_data.
REQ-017 Port: busy  output  1  high whenever state is not IDLE.
REQ-018 Port: op_count  output  CNT_W  number of completed responses.

Function
REQ-019 The block SHALL implement a four-state FSM: IDLE, ISSUE, CAPT, RESP.
REQ-020 IDLE: the block SHALL assert req_ready only for the granted requester in the same cycle that requester's req_valid is high; req_ready SHALL be 0 in all other states.
REQ-021 Arbitration: with one valid requester, grant it; with both valid, grant the requester other than last_grant (round-robin).
REQ-022 On a handshake (req_valid[g] and req_ready[g]), the block SHALL latch req_a, req_b, req_op of requester g into the fpu_a, fpu_b, fpu_opcode registers, record g as owner and last_grant, and move to ISSUE.
REQ-023 fpu_a, fpu_b and fpu_opcode SHALL be registered outputs, held stable from the edge that ends IDLE until the next handshake.
REQ-024 ISSUE SHALL last exactly one cycle, then move to CAPT. The FPU samples its operands at the end of this cycle.
REQ-025 CAPT SHALL last exactly one cycle, load fpu_result into resp_data and the owner into resp_id at its end, and move to RESP.
REQ-026 RESP: resp_valid SHALL be 1; resp_data and resp_id SHALL be held stable until the handshake.
REQ-027 On resp_valid and resp_ready in RESP, the block SHALL clear resp_valid, increment op_count (modulo 2^CNT_W, wrapping to 0), and return to IDLE.
REQ-028 Latency: if the request handshake occurs in cycle N, resp_valid SHALL first be high in cycle N+3; minimum issue interval is 4 cycles with resp_ready held high.
REQ-029 New requests SHALL NOT be accepted outside IDLE, so at most one operation is in flight.
REQ-030 Held (unaccepted) requests SHALL NOT be dropped; a requester keeping req_valid high is eventually granted within two grants.
REQ-031 resp_ready high while not in RESP SHALL have no effect.

Reset
REQ-032 While rst is high at a clock edge, the block SHALL enter IDLE and clear resp_valid, resp_data, resp_id, fpu_a, fpu_b, fpu_opcode and op_count to 0. last_grant SHALL be set to 1, so requester 0 wins the first contention.
REQ-033 During the rst cycle, req_ready SHALL be 0.
REQ-034 Reset asserted in ISSUE, CAPT or RESP SHALL abandon the in-flight operation without emitting a response. The next response SHALL belong to a request accepted after reset.

Verification
REQ-035 Single request: requester 0 sends a=0x3F800000, b=0x40000000, op=000, with resp_ready=1; the model FPU returns 0x40400000. Required: resp_valid high 3 cycles after the handshake, resp_data=0x40400000, resp_id=0, op_count=1.
REQ-036 Contention after reset: both requesters valid continuously with resp_ready=1. Required: grants alternate 0,1,0,1; resp_id sequence 0,1,0,1; op_count=4 after 16 cycles.
REQ-037 Backpressure: resp_ready=0 for 5 cycles in RESP. Required: resp_valid, resp_data and resp_id stay stable, req_ready stays 00, and fpu_* stays unchanged until resp_ready=1.
REQ-038 Reset mid-operation: assert rst in CAPT. Required: no response, all outputs 0, busy=0, and op_count=0 next cycle.
REQ-039 Counter wrap with CNT_W=4: 16 completed operations. Required: op_count returns to 0.
REQ-040 Undefined opcode 111 passed through. Required: fpu_opcode=111 during ISSUE, and resp_data equals the model FPU output (0).
